// File: rtl/keep_one_in_n_unzip.sv
// keep_one_in_n_unzip: unpacks one 32-bit word of four I/Q symbols into four samples
`timescale 1ns/1ps
module keep_one_in_n_unzip #(
  parameter int WIDTH     = 32,
  parameter bit FILL_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);
  localparam logic [23:0] FILL = FILL_MODE ? 24'h800000 : 24'h000000;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             last_q, last_d, full_q, full_d;
  logic [1:0]       idx, idx_d;
  logic             out_fire, in_fire;
  logic [7:0]       lane;
  assign out_fire = full_q & o_tready;
  assign i_tready = ~full_q | (out_fire & (idx == 2'd3));
  assign in_fire  = i_tvalid & i_tready;
  assign lane     = idx == 2'd0 ? hold_q[23:16] :
                    idx == 2'd1 ? hold_q[7:0]   :
                    idx == 2'd2 ? hold_q[31:24] : hold_q[15:8];
  assign o_tdata  = {lane, FILL};
  assign o_tvalid = full_q;
  assign o_tlast  = full_q & last_q & (idx == 2'd3);
  // next state: a new word (re)starts at idx0, otherwise step through lanes on each handshake
  always_comb begin
    hold_d = hold_q;
    last_d = last_q;
    full_d = full_q;
    idx_d  = idx;
    if (in_fire) begin
      hold_d = i_tdata;
      last_d = i_tlast;
      full_d = 1'b1;
      idx_d  = 2'd0;
    end else if (out_fire) begin
      full_d = idx != 2'd3;
      idx_d  = idx + 2'd1;
    end
  end
  // state register; reset drops any partially emitted word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      last_q <= 1'b0;
      full_q <= 1'b0;
      idx    <= 2'd0;
    end else begin
      hold_q <= hold_d;
      last_q <= last_d;
      full_q <= full_d;
      idx    <= idx_d;
    end
  end
endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// tb_keep_one_in_n_unzip: directed and randomized checks of the 1-to-4 symbol unpacker
`timescale 1ns/1ps
module tb_keep_one_in_n_unzip;
  logic        clk, reset;
  logic [31:0] i_tdata, o_tdata, f_tdata;
  logic        i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;
  logic        f_tlast, f_tvalid, f_i_tready;
  int          n_cmp, n_err;
  logic [7:0]  sym [4000];
  bit          lst [1000];

  keep_one_in_n_unzip #(.WIDTH(32), .FILL_MODE(1'b0)) dut (
    .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
    .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready));

  keep_one_in_n_unzip #(.WIDTH(32), .FILL_MODE(1'b1)) dut_fill (
    .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
    .i_tready(f_i_tready), .o_tdata(f_tdata), .o_tlast(f_tlast), .o_tvalid(f_tvalid),
    .o_tready(o_tready));

  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b1;
    #3;
    n_cmp++;
    if (o_tvalid !== 1'b0 || o_tlast !== 1'b0 || i_tready !== 1'b1 || f_i_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset: got v=%b l=%b rdy=%b frdy=%b want v=0 l=0 rdy=1 frdy=1", o_tvalid, o_tlast, i_tready, f_i_tready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got v=%b rdy=%b want v=0 rdy=1", o_tvalid, i_tready);
    end
  endtask

  task automatic test_single;
    logic [31:0] e [4];
    e = '{32'hBB000000, 32'hDD000000, 32'hAA000000, 32'hCC000000};
    @(posedge clk); #1;
    i_tdata = 32'hAABBCCDD; i_tlast = 1'b1; i_tvalid = 1'b1; o_tready = 1'b1;
    @(posedge clk); #1;
    i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = 'x;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_tvalid !== 1'b1 || o_tdata !== e[k] || o_tlast !== (k == 3)) begin
        n_err++;
        $display("FAIL single[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, o_tvalid, o_tdata, o_tlast, e[k], k == 3);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (o_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain: got v=%b want v=0", o_tvalid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b [8];
    b = '{8'h22, 8'h44, 8'h11, 8'h33, 8'h66, 8'h88, 8'h55, 8'h77};
    @(posedge clk); #1;
    i_tdata = 32'h11223344; i_tlast = 1'b0; i_tvalid = 1'b1; o_tready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (i_tready !== 1'b1 || o_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_empty: got rdy=%b v=%b want rdy=1 v=0", i_tready, o_tvalid);
    end
    @(posedge clk); #1;
    i_tdata = 32'h55667788;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_tvalid !== 1'b1 || o_tdata !== {b[k], 24'h0} || i_tready !== (k % 4 == 3)) begin
        n_err++;
        $display("FAIL b2b[%0d]: got v=%b d=%h rdy=%b want v=1 d=%h rdy=%b", k, o_tvalid, o_tdata, i_tready, {b[k], 24'h0}, k % 4 == 3);
      end
      if (k == 3) begin
        @(posedge clk); #1;
        i_tvalid = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (o_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got v=%b want v=0", o_tvalid);
    end
  endtask

  task automatic test_stall;
    bit         pat [4];
    logic [7:0] e [4];
    int         got, cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    e = '{8'h0B, 8'h0D, 8'h0A, 8'h0C};
    @(posedge clk); #1;
    i_tdata = 32'h0A0B0C0D; i_tlast = 1'b1; i_tvalid = 1'b1; o_tready = 1'b1;
    @(posedge clk); #1;
    i_tvalid = 1'b0; i_tlast = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 20) begin
      o_tready = pat[cyc % 4];
      @(negedge clk);
      n_cmp++;
      if (o_tvalid !== 1'b1 || o_tdata !== {e[got], 24'h0} || o_tlast !== (got == 3)) begin
        n_err++;
        $display("FAIL stall[cyc %0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b", cyc, o_tvalid, o_tdata, o_tlast, {e[got], 24'h0}, got == 3);
      end
      if (o_tready) got++;
      cyc++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (cyc != 8 || got != 4) begin
      n_err++;
      $display("FAIL stall_cycles: got cyc=%0d samples=%0d want cyc=8 samples=4", cyc, got);
    end
    o_tready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_drain: got v=%b want v=0", o_tvalid);
    end
  endtask

  task automatic test_fill;
    logic [31:0] e [4];
    e = '{32'h02800000, 32'h04800000, 32'h01800000, 32'h03800000};
    @(posedge clk); #1;
    i_tdata = 32'h01020304; i_tlast = 1'b0; i_tvalid = 1'b1; o_tready = 1'b1;
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (f_tvalid !== 1'b1 || f_tdata !== e[k] || f_tlast !== 1'b0) begin
        n_err++;
        $display("FAIL fill[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=0", k, f_tvalid, f_tdata, f_tlast, e[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] e [4];
    e = '{32'hE0000000, 32'hC0000000, 32'hF0000000, 32'hD0000000};
    @(posedge clk); #1;
    i_tdata = 32'h12345678; i_tlast = 1'b1; i_tvalid = 1'b1; o_tready = 1'b1;
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (o_tvalid !== 1'b1 || o_tdata !== 32'h78000000) begin
      n_err++;
      $display("FAIL rst_mid_pre: got v=%b d=%h want v=1 d=78000000", o_tvalid, o_tdata);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (o_tvalid !== 1'b0 || o_tlast !== 1'b0 || i_tready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_async: got v=%b l=%b rdy=%b want v=0 l=0 rdy=1", o_tvalid, o_tlast, i_tready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    i_tdata = 32'hF0E0D0C0; i_tlast = 1'b0; i_tvalid = 1'b1;
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_tvalid !== 1'b1 || o_tdata !== e[k] || o_tlast !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=0", k, o_tvalid, o_tdata, o_tlast, e[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stress;
    int          wi, oi, cyc, b, in_last, out_last, want_last;
    bit          stalled, exp_last;
    logic [31:0] sd;
    logic        sl;
    want_last = 0;
    for (int w = 0; w < 1000; w++) begin
      for (int j = 0; j < 4; j++) sym[4*w+j] = 8'($urandom_range(255));
      lst[w] = ($urandom_range(3) == 0);
      if (lst[w]) want_last++;
    end
    wi = 0; oi = 0; cyc = 0; in_last = 0; out_last = 0; stalled = 0; sd = '0; sl = 1'b0;
    @(posedge clk); #1;
    while (oi < 4000 && cyc < 30000) begin
      b = (wi < 1000) ? wi : 0;
      i_tvalid = (wi < 1000) && ($urandom_range(3) != 0);
      i_tdata = i_tvalid ? {sym[4*b+2], sym[4*b], sym[4*b+3], sym[4*b+1]} : $urandom;
      i_tlast = i_tvalid ? lst[b] : 1'($urandom_range(1));
      o_tready = $urandom_range(9) < 7;
      @(negedge clk);
      if (stalled) begin
        n_cmp++;
        if (o_tvalid !== 1'b1 || o_tdata !== sd || o_tlast !== sl) begin
          n_err++;
          $display("FAIL stress_hold[cyc %0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b", cyc, o_tvalid, o_tdata, o_tlast, sd, sl);
        end
      end
      if (o_tvalid && o_tready) begin
        exp_last = (oi % 4 == 3) && lst[oi/4];
        n_cmp++;
        if (o_tdata !== {sym[oi], 24'h0} || o_tlast !== exp_last) begin
          n_err++;
          $display("FAIL stress[%0d]: got d=%h l=%b want d=%h l=%b", oi, o_tdata, o_tlast, {sym[oi], 24'h0}, exp_last);
        end
        if (o_tlast) out_last++;
        oi++;
      end
      stalled = o_tvalid && !o_tready;
      sd = o_tdata;
      sl = o_tlast;
      if (i_tvalid && i_tready) begin
        if (i_tlast) in_last++;
        wi++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    i_tvalid = 1'b0;
    n_cmp++;
    if (oi != 4000) begin
      n_err++;
      $display("FAIL stress_timeout: got samples=%0d want 4000", oi);
    end
    n_cmp++;
    if (out_last != want_last || in_last != want_last) begin
      n_err++;
      $display("FAIL stress_tlast: got out=%0d in=%0d want %0d", out_last, in_last, want_last);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0;
    clk = 1'b0; reset = 1'b1;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_fill();
    test_reset_mid();
    test_stress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
